// File: rtl/temporal_rank_sorter.sv
// temporal_rank_sorter
//   Windowed race-logic sorter. After a start pulse, N monotone spike lines are
//   sampled for T_W cycles. Each first 0->1 arrival receives a rank (earlier
//   arrival first, same-cycle ties to the lower channel index). The block keeps
//   a registered thermometer of the arrival count, flags the first k_wta
//   arrivals as winners, and, once the window closes, streams the sorted
//   (channel, arrival time) list over a valid/ready port.
//
// Ports
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   start          opens a window; honoured only in IDLE
//   k_wta          winner count, latched on an accepted start
//   spike_in       N spike lines; a rising edge marks arrival
//   sorted_out     thermometer of arrivals, bit 0 rises first
//   win_mask       per-channel winner flags
//   arr_count      channels arrived so far in this window
//   busy           high in ACQ and DRAIN
//   rd_valid/rd_ready/rd_idx/rd_time/rd_last   readout stream
//   done           one-cycle pulse when readout finishes
//
// Readout handshake: an entry transfers on a cycle where rd_valid and rd_ready
// are both high at the rising edge. rd_valid never drops and rd_idx/rd_time/
// rd_last never change while rd_valid is high and rd_ready is low; rd_valid
// does not depend on rd_ready.
module temporal_rank_sorter #(
  parameter int N   = 32,
  parameter int T_W = 64,
  parameter int IW  = $clog2(N),
  parameter int CW  = $clog2(N + 1),
  parameter int TW  = $clog2(T_W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] k_wta,
  input  logic [N-1:0]  spike_in,
  output logic [N-1:0]  sorted_out,
  output logic [N-1:0]  win_mask,
  output logic [CW-1:0] arr_count,
  output logic          busy,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [IW-1:0] rd_idx,
  output logic [TW-1:0] rd_time,
  output logic          rd_last,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  seen_q, seen_d;
  logic [N-1:0]  sorted_q, sorted_d;
  logic [N-1:0]  win_q, win_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] k_q, k_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [IW-1:0] order_q [N];
  logic [IW-1:0] order_d [N];
  logic [TW-1:0] time_q  [N];
  logic [TW-1:0] time_d  [N];

  logic [N-1:0]  new_arr;
  logic [CW-1:0] run_cnt;
  logic          window_end;
  logic          entry_valid;
  logic          rd_fire;

  assign window_end  = (timer_q == TW'(T_W - 1));
  assign entry_valid = (state_q == S_DRAIN) && (ptr_q < cnt_q);
  assign rd_fire     = entry_valid && rd_ready;

  // ---------------------------------------------------------------------------
  // State register (plus all datapath registers)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      seen_q   <= '0;
      sorted_q <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      k_q      <= '0;
      ptr_q    <= '0;
      timer_q  <= '0;
      for (int i = 0; i < N; i++) begin
        order_q[i] <= '0;
        time_q[i]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      seen_q   <= seen_d;
      sorted_q <= sorted_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      ptr_q    <= ptr_d;
      timer_q  <= timer_d;
      order_q  <= order_d;
      time_q   <= time_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)       state_d = S_ACQ;
      S_ACQ:   if (window_end)  state_d = S_DRAIN;
      // Leaves once no entry is pending; that cycle is the done cycle.
      S_DRAIN: if (!entry_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    seen_d   = seen_q;
    sorted_d = sorted_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    ptr_d    = ptr_q;
    timer_d  = timer_q;
    order_d  = order_q;
    time_d   = time_q;
    new_arr  = '0;
    run_cnt  = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          seen_d   = '0;
          sorted_d = '0;
          win_d    = '0;
          cnt_d    = '0;
          ptr_d    = '0;
          timer_d  = '0;
          k_d      = k_wta;
        end
      end

      S_ACQ: begin
        // seen is sticky, so a line that drops and re-rises is not new.
        new_arr = spike_in & ~seen_q;
        // run_cnt walks up the channels in index order: at channel i it equals
        // arr_count plus the number of new arrivals below i, i.e. i's rank.
        for (int i = 0; i < N; i++) begin
          if (new_arr[i]) begin
            order_d[run_cnt[IW-1:0]] = IW'(i);
            time_d[run_cnt[IW-1:0]]  = timer_q;
            win_d[i]                 = (run_cnt < k_q);
            run_cnt                  = run_cnt + CW'(1);
          end
        end
        seen_d = seen_q | new_arr;
        cnt_d  = run_cnt;
        for (int i = 0; i < N; i++) begin
          sorted_d[i] = (CW'(i) < run_cnt);
        end
        // Timer holds on the final sample so rd_time range stays 0..T_W-1.
        if (!window_end) timer_d = timer_q + TW'(1);
      end

      S_DRAIN: begin
        if (rd_fire) ptr_d = ptr_q + CW'(1);
      end

      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy     = (state_q != S_IDLE);
    rd_valid = entry_valid;
    rd_idx   = '0;
    rd_time  = '0;
    rd_last  = 1'b0;
    done     = (state_q == S_DRAIN) && !entry_valid;
    if (entry_valid) begin
      rd_idx  = order_q[ptr_q[IW-1:0]];
      rd_time = time_q[ptr_q[IW-1:0]];
      rd_last = (ptr_q == cnt_q - CW'(1));
    end
  end

  assign sorted_out = sorted_q;
  assign win_mask   = win_q;
  assign arr_count  = cnt_q;

endmodule

// File: tb/tb_temporal_rank_sorter.sv
// Bench for temporal_rank_sorter with N=8, T_W=16. Stimulus windows are driven
// from the main process; expected readout entries are queued before each
// window and a separate monitor pops and compares them on every handshake.
module tb_temporal_rank_sorter;

  localparam int N   = 8;
  localparam int T_W = 16;
  localparam int IW  = 3;
  localparam int CW  = 4;
  localparam int TW  = 4;
  localparam int EW  = 1 + IW + TW;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] k_wta = '0;
  logic [N-1:0]  spike_in = '0;
  logic          rd_ready = 1'b0;
  logic [N-1:0]  sorted_out, win_mask;
  logic [CW-1:0] arr_count;
  logic          busy, rd_valid, rd_last, done;
  logic [IW-1:0] rd_idx;
  logic [TW-1:0] rd_time;

  always #5 clk = ~clk;

  temporal_rank_sorter #(.N(N), .T_W(T_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .k_wta      (k_wta),
    .spike_in   (spike_in),
    .sorted_out (sorted_out),
    .win_mask   (win_mask),
    .arr_count  (arr_count),
    .busy       (busy),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_idx     (rd_idx),
    .rd_time    (rd_time),
    .rd_last    (rd_last),
    .done       (done)
  );

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int errors   = 0;
  int hs_cnt   = 0;
  int done_cnt = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_e(input logic [IW-1:0] idx, input logic [TW-1:0] t, input logic last);
    exp_q.push_back({last, idx, t});
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops on every handshake, checks stability while stalled
  // ---------------------------------------------------------------------------
  initial begin : monitor
    logic [EW-1:0] cur, held, e;
    logic holding;
    holding = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      cur = {rd_last, rd_idx, rd_time};
      if (holding && rd_valid) chk("stall_stable", cur, held);
      if (rd_valid && rd_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL readout_extra actual=0x%0h required=none", cur);
        end else begin
          e = exp_q.pop_front();
          chk("readout_entry", cur, e);
        end
      end
      holding = rd_valid && !rd_ready;
      held    = cur;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers and hand-written stimulus tables
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] spike_pat(input int tc, input int t);
    logic [N-1:0] p;
    p = '0;
    case (tc)
      0: begin
        if (t >= 2) p[5] = 1'b1;
        if (t >= 4) begin p[1] = 1'b1; p[6] = 1'b1; end
        if (t >= 9) p[0] = 1'b1;
      end
      1: p = 8'hFF;
      3: if (t == 1 || t >= 7) p[3] = 1'b1;
      default: p = '0;
    endcase
    return p;
  endfunction

  // Arrival count visible after the sample taken at timer value t.
  function automatic int exp_cnt(input int tc, input int t);
    case (tc)
      0: return (t >= 9) ? 4 : (t >= 4) ? 3 : (t >= 2) ? 1 : 0;
      1: return 8;
      3: return (t >= 1) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic logic [N-1:0] therm(input int c);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < c; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic push_tc0();
    push_e(3'd5, 4'd2, 1'b0);
    push_e(3'd1, 4'd4, 1'b0);
    push_e(3'd6, 4'd4, 1'b0);
    push_e(3'd0, 4'd9, 1'b1);
  endtask

  task automatic run_window(input int tc, input int k, input bit stall,
                            input logic [N-1:0] exp_win, input int n_ent);
    int cyc, hs0, dc0;
    bit got;
    k_wta = CW'(k);
    start = 1'b1;
    tick();
    start = 1'b0;
    k_wta = '0;
    chk("start_busy", busy, 1);
    chk("start_clear_sorted", sorted_out, 0);
    for (int t = 0; t < T_W; t++) begin
      spike_in = spike_pat(tc, t);
      start    = (tc == 3 && t == 3);
      tick();
      start    = 1'b0;
      chk("sorted_out", sorted_out, therm(exp_cnt(tc, t)));
      chk("arr_count", arr_count, exp_cnt(tc, t));
      chk("busy_window", busy, 1);
    end
    spike_in = '0;
    chk("win_mask", win_mask, exp_win);
    hs0 = hs_cnt;
    dc0 = done_cnt;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 300) begin
      rd_ready = stall ? (cyc % 4 == 3) : 1'b1;
      if (done) got = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    chk("done_seen", got, 1);
    chk("done_cycle", cyc, stall ? 4 * n_ent : n_ent);
    tick();
    rd_ready = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
    chk("handshakes", hs_cnt - hs0, n_ent);
    chk("done_pulses", done_cnt - dc0, 1);
    chk("queue_empty", exp_q.size(), 0);
    chk("sorted_persist", sorted_out, therm(exp_cnt(tc, T_W - 1)));
    chk("win_persist", win_mask, exp_win);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    int dc;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_sorted", sorted_out, 0);
    chk("rst_win", win_mask, 0);
    chk("rst_count", arr_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    // Basic ordering with k=3.
    push_tc0();
    run_window(0, 3, 1'b0, 8'h62, 4);

    // Same stimulus, consumer stalls 3 cycles per entry.
    push_tc0();
    run_window(0, 3, 1'b1, 8'h62, 4);

    // All channels at t0, k=0: index order, no winners.
    for (int i = 0; i < N; i++) push_e(IW'(i), 4'd0, (i == N - 1));
    run_window(1, 0, 1'b0, 8'h00, 8);

    // Empty window: done on the first DRAIN cycle.
    run_window(2, 3, 1'b0, 8'h00, 0);

    // Spikes while idle are ignored.
    spike_in = 8'hFF;
    repeat (3) tick();
    chk("idle_spike_sorted", sorted_out, 0);
    chk("idle_spike_count", arr_count, 0);
    chk("idle_spike_busy", busy, 0);
    spike_in = '0;
    tick();

    // Glitch then re-rise on ch3, mid-window start, k >= N.
    push_e(3'd3, 4'd1, 1'b1);
    run_window(3, 8, 1'b0, 8'h08, 1);

    // Reset in the middle of a window.
    k_wta = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 5; t++) begin
      spike_in = spike_pat(0, t);
      tick();
    end
    chk("pre_abort_sorted", sorted_out, 8'h07);
    rst_n = 1'b0;
    #1;
    chk("abort_sorted", sorted_out, 0);
    chk("abort_win", win_mask, 0);
    chk("abort_count", arr_count, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    exp_q.delete();
    spike_in = '0;
    dc = done_cnt;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("abort_no_done", done_cnt - dc, 0);
    chk("abort_idle", busy, 0);

    // Clean window after the abort.
    push_tc0();
    run_window(0, 3, 1'b0, 8'h62, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/temporal_rank_sorter.md
Name: temporal_rank_sorter

Overview:
- Clocked, parametrised successor to the 32-input combinational bitonic sorter for race-logic spike lines.
- Samples N monotone 0->1 spike lines over a fixed gamma window and drives a registered thermometer output equivalent to the sorter's ascending-transition output.
- Also assigns each arriving channel a rank, flags k-winner-take-all winners, and streams the sorted (channel, arrival time) list out after the window closes.
- Sits between sensory encoders and the column/WTA stage.

Parameters:
- N, 32, number of spike channels (>=2).
- T_W, 64, window length in clock cycles (>=2).
- IW, $clog2(N), channel index width.
- CW, $clog2(N+1), count/rank width.
- TW, $clog2(T_W), arrival-time width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that opens a window; honoured only in IDLE.
- k_wta  in  CW  number of winners; sampled on an accepted start.
- spike_in  in  N  spike lines; a 0->1 edge marks arrival.
- sorted_out  out  N  thermometer of arrivals; bit 0 rises first.
- win_mask  out  N  per-channel winner flags.
- arr_count  out  CW  channels arrived so far in this window.
- busy  out  1  high in ACQ and DRAIN.
- rd_valid  out  1  readout entry valid.
- rd_ready  in  1  readout consumer ready.
- rd_idx  out  IW  channel index of the current readout entry.
- rd_time  out  TW  arrival time of the current readout entry.
- rd_last  out  1  marks the final readout entry.
- done  out  1  one-cycle pulse at end of readout.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; seen, win, order, time, timer and k registers cleared. Reset mid-ACQ or mid-DRAIN abandons the window with no done pulse.
- FSM states: IDLE, ACQ, DRAIN.
- IDLE:
  - start=1 -> ACQ next cycle; timer=0; seen, sorted_out, win_mask and arr_count cleared; k_wta latched into k_q.
  - spike_in is ignored.
- ACQ, each cycle with timer value t:
  - new[i] = spike_in[i] & ~seen[i].
  - Each new channel gets rank r = arr_count + popcount(new[i-1:0]); same-cycle ties go to the lower index.
  - order[r] <= i and time[r] <= t.
  - win_mask[i] <= (r < k_q).
  - seen |= new; arr_count += popcount(new).
  - sorted_out <= thermometer(arr_count_next): bits [arr_count_next-1:0] are 1. Latency is exactly 1 cycle from the sampled spike to the output.
  - seen is sticky: a line dropping back to 0 is ignored and a later re-rise is not a new arrival.
  - start is ignored during ACQ.
  - When t = T_W-1 (final sample cycle), the next state is DRAIN and the timer holds.
- DRAIN:
  - sorted_out, win_mask and arr_count hold their values.
  - Read pointer p starts at 0. While p < arr_count: rd_valid=1, rd_idx=order[p], rd_time=time[p], rd_last=(p==arr_count-1).
  - The pointer advances only on rd_valid & rd_ready. rd_* are stable while rd_valid=1 and rd_ready=0.
  - After the last handshake: done=1 for one cycle, rd_valid=0, state IDLE.
  - If arr_count=0 when entering DRAIN: no entries, done pulses on the first DRAIN cycle, then IDLE.
  - start is ignored during DRAIN.
- Output persistence:
  - sorted_out, win_mask and arr_count persist in IDLE until the next accepted start.
  - busy=1 exactly in ACQ and DRAIN.
- k_wta rules: k_q=0 -> no winners; k_q >= N -> every arriving channel wins; non-arriving channels never win.
- Width rules:
  - arr_count saturates naturally at N.
  - Arrival time range is 0..T_W-1.
  - popcount and prefix-count logic is combinational within one cycle.

Test Plan:
- N=8, T_W=16, k_wta=3, start at cycle 0. Rises: ch5@t2, ch1@t4, ch6@t4, ch0@t9; others never rise.
  - sorted_out=0x01 after t2, 0x07 after t4, 0x0F after t9.
  - win_mask=bits{5,1,6}.
  - Readout (5,2), (1,4), (6,4), (0,9); rd_last on the 4th entry; then done.
- Same stimulus with rd_ready held low 3 cycles per entry -> rd_idx/rd_time stable while stalled; identical sequence; exactly 4 handshakes.
- All 8 channels rise at t0 with k_wta=0:
  - sorted_out=0xFF one cycle later.
  - Readout idx 0..7, all time 0.
  - win_mask=0.
- No spikes in window -> DRAIN emits nothing; done pulses at cycle 17 after start; sorted_out=0.
- Glitch and sequencing checks:
  - ch3 pulses high at t1, low at t2, high again at t7 -> single entry (3,1).
  - start pulsed mid-ACQ -> ignored; busy stays high.
  - spikes asserted in IDLE -> no effect.
- rst_n low at t5 of ACQ -> all outputs 0 immediately; no done pulse. A new start after release runs a clean window.
